commit_fence_ctrl: RTL and testbench

Sequencer for the fence-class instructions retiring on commit port 0: FENCE, FENCE.I and SFENCE.VMA. It sits between the commit stage and the cache/TLB flush interfaces. For each request it waits for the store buffer to drain, then issues the D$ flush, I$ flush and TLB flush steps the operation needs. When the sequence finishes it pulses `done_o`, which the commit stage uses as commit acknowledge and pipeline-flush trigger. A stall watchdog flags hung drains or flushes.

---
 rtl/commit_fence_ctrl.sv | 152 +++++++++++++++
 tb/tb_commit_fence_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_fence_ctrl.sv
// rtl/commit_fence_ctrl.sv - fence-class commit sequencer (FENCE, FENCE.I, SFENCE.VMA)
//
// Sequences store-buffer drain, D$ flush, I$ flush and TLB flush for the
// fence instruction retiring on commit port 0, then pulses done_o as the
// commit acknowledge / pipeline flush trigger. A watchdog flags a drain or
// D$ flush that stalls for TIMEOUT_CYCLES.
//
// Optional feature: define FENCE_PERF_CNT_EN to build the 32-bit stall
// performance counter behind stall_cnt_o; otherwise stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i, req_op_i  fence request and op (0 FENCE, 1 FENCE_I, 2 SFENCE_VMA, 3 reserved)
//   halt_i                 blocks acceptance of new requests while idle
//   no_st_pending_i        store buffer empty
//   dcache_flush_o/_ack_i  D$ flush request (level) and completion
//   icache_flush_o         I$ flush pulse
//   tlb_flush_o            TLB flush pulse
//   done_o                 one-cycle completion pulse
//   busy_o                 sequence in progress
//   bad_op_o               completion of a reserved op (with done_o)
//   timeout_o              sticky watchdog flag
//   stall_cnt_o            cumulative drain/flush stall cycles
module commit_fence_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic        halt_i,
  input  logic        no_st_pending_i,
  output logic        dcache_flush_o,
  input  logic        dcache_flush_ack_i,
  output logic        icache_flush_o,
  output logic        tlb_flush_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        bad_op_o,
  output logic        timeout_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_DFLUSH,
    S_IFLUSH,
    S_TLB,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_FENCE_I = 2'd1;
  localparam logic [1:0] OP_SFENCE  = 2'd2;
  localparam logic [1:0] OP_BAD     = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_inc;
  logic             wd_enter;
  logic             wd_stall;
  logic             timeout_q;
  logic             accept;

  assign accept = (state_q == S_IDLE) && req_valid_i && !halt_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (req_op_i == OP_BAD) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (no_st_pending_i) begin
          state_d = (op_q == OP_SFENCE) ? S_TLB : S_DFLUSH;
        end
      end
      S_DFLUSH: begin
        if (dcache_flush_ack_i) begin
          state_d = (op_q == OP_FENCE_I) ? S_IFLUSH : S_DONE;
        end
      end
      S_IFLUSH: state_d = S_DONE;
      S_TLB:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The watchdog restarts whenever a new wait phase begins, so a long drain
  // does not eat into the budget of the following D$ flush.
  assign wd_enter = ((state_d == S_DRAIN)  && (state_q != S_DRAIN)) ||
                    ((state_d == S_DFLUSH) && (state_q != S_DFLUSH));
  assign wd_stall = (state_q == S_DRAIN) || (state_q == S_DFLUSH);
  assign wd_inc   = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + CNT_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= req_op_i;
      end
      if (wd_enter) begin
        wd_cnt_q <= '0;
      end else if (wd_stall) begin
        wd_cnt_q <= wd_inc;
        // Flag on the edge that stores the threshold value; no forced exit.
        if (wd_inc == TIMEOUT_VAL) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign dcache_flush_o = (state_q == S_DFLUSH);
  assign icache_flush_o = (state_q == S_IFLUSH);
  assign tlb_flush_o    = (state_q == S_TLB);
  assign done_o         = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE);
  assign bad_op_o       = (state_q == S_DONE) && (op_q == OP_BAD);
  assign timeout_o      = timeout_q;

`ifdef FENCE_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= 32'd0;
    end else if (((state_q == S_DRAIN)  && !no_st_pending_i) ||
                 ((state_q == S_DFLUSH) && !dcache_flush_ack_i)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_commit_fence_ctrl.sv
// tb/tb_commit_fence_ctrl.sv - scoreboard bench for commit_fence_ctrl
module tb_commit_fence_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic        halt = 1'b0;
  logic        no_st = 1'b0;
  logic        ack = 1'b0;
  logic        dcache_flush, icache_flush, tlb_flush, done, busy, bad_op, timeout;
  logic [31:0] stall_cnt;

  commit_fence_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_op_i           (req_op),
    .halt_i             (halt),
    .no_st_pending_i    (no_st),
    .dcache_flush_o     (dcache_flush),
    .dcache_flush_ack_i (ack),
    .icache_flush_o     (icache_flush),
    .tlb_flush_o        (tlb_flush),
    .done_o             (done),
    .busy_o             (busy),
    .bad_op_o           (bad_op),
    .timeout_o          (timeout),
    .stall_cnt_o        (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          done_cyc;
    bit          bad;
    int          df_first;
    int          df_cnt;
    int          ic_cyc;
    int          tlb_cyc;
    int          busy_cnt;
    bit          to;
    int          to_rise;
    logic [31:0] stall;
  } exp_t;

  exp_t sb[$];

  // Reference state carried across sequences.
  bit          exp_to = 1'b0;
  logic [31:0] exp_stall = 32'd0;

  // Observed activity since the previous done_o.
  int df_first, df_cnt, ic_cyc, ic_cnt, tlb_cyc, tlb_cnt, busy_cnt, to_rise;
  bit to_prev;

  task automatic clear_obs();
    df_first = -1; df_cnt = 0; ic_cyc = -1; ic_cnt = 0;
    tlb_cyc = -1; tlb_cnt = 0; busy_cnt = 0; to_rise = -1;
  endtask

  initial clear_obs();

  always @(negedge clk) begin
    if (!rst_n) begin
      clear_obs();
      to_prev = 1'b0;
    end else begin
      if (dcache_flush) begin
        if (df_first < 0) df_first = cyc;
        df_cnt++;
      end
      if (icache_flush) begin ic_cyc = cyc; ic_cnt++; end
      if (tlb_flush) begin tlb_cyc = cyc; tlb_cnt++; end
      if (busy) busy_cnt++;
      if (timeout && !to_prev) to_rise = cyc;
      to_prev = timeout;
      if (bad_op && !done) check("bad_op_without_done", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("bad_op", bad_op, e.bad);
          check("dflush_first", df_first, e.df_first);
          check("dflush_cycles", df_cnt, e.df_cnt);
          check("iflush_cycle", ic_cyc, e.ic_cyc);
          check("iflush_pulses", ic_cnt, (e.ic_cyc < 0) ? 0 : 1);
          check("tlb_cycle", tlb_cyc, e.tlb_cyc);
          check("tlb_pulses", tlb_cnt, (e.tlb_cyc < 0) ? 0 : 1);
          check("busy_cycles", busy_cnt, e.busy_cnt);
          check("timeout", timeout, e.to);
          check("timeout_rise", to_rise, e.to_rise);
`ifdef FENCE_PERF_CNT_EN
          check("stall_cnt", stall_cnt, e.stall);
`else
          check("stall_cnt_tied", stall_cnt, 0);
`endif
        end
        clear_obs();
      end
    end
  end

  // One sequence: gap idle cycles, h halted request cycles, then the
  // accepted request. p = cycles of pending stores in drain, a = cycles of
  // withheld ack in D$ flush.
  task automatic run_txn(input logic [1:0] op, input int p, input int a,
                         input int h, input int gap);
    int   n, dn, df0, dfc, ic, tl, tr, st;
    exp_t e;
    repeat (gap) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 2'($urandom); halt = 1'($urandom);
      no_st = 1'($urandom); ack = 1'($urandom);
    end
    repeat (h) begin
      @(posedge clk); #1;
      req_valid = 1'b1; halt = 1'b1; req_op = 2'($urandom);
      no_st = 1'($urandom); ack = 1'($urandom);
    end
    @(posedge clk); #1;
    n = cyc;
    req_valid = 1'b1; halt = 1'b0; req_op = op;
    no_st = 1'($urandom); ack = 1'($urandom);

    df0 = -1; dfc = 0; ic = -1; tl = -1; tr = -1; st = 0;
    case (op)
      2'd3: dn = n + 1;
      2'd2: begin dn = n + p + 3; tl = n + p + 2; st = p; end
      2'd1: begin
        dn = n + p + a + 4; ic = n + p + a + 3;
        df0 = n + p + 2; dfc = a + 1; st = p + a;
      end
      default: begin
        dn = n + p + a + 3;
        df0 = n + p + 2; dfc = a + 1; st = p + a;
      end
    endcase
    // Threshold is reached once 16 cycles have been spent in D$ flush.
    if (op <= 2'd1 && a >= 15 && !exp_to) begin
      tr = df0 + 16;
      exp_to = 1'b1;
    end
    exp_stall = exp_stall + 32'(st);
    e.done_cyc = dn; e.bad = (op == 2'd3); e.df_first = df0; e.df_cnt = dfc;
    e.ic_cyc = ic; e.tlb_cyc = tl; e.busy_cnt = dn - n; e.to = exp_to;
    e.to_rise = tr; e.stall = exp_stall;
    sb.push_back(e);

    for (int t = n + 1; t <= dn; t++) begin
      @(posedge clk); #1;
      req_valid = (t < dn) ? 1'($urandom) : 1'b0;
      req_op = 2'($urandom);
      halt = 1'($urandom);
      if (op != 2'd3 && t <= n + p) no_st = 1'b0;
      else if (op != 2'd3 && t == n + p + 1) no_st = 1'b1;
      else no_st = 1'($urandom);
      if (op <= 2'd1 && t >= df0 && t <= df0 + a) ack = (t == df0 + a);
      else ack = 1'($urandom);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dflush", dcache_flush, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;

    run_txn(2'd0, 0, 0, 0, 1);   // FENCE best case
    run_txn(2'd1, 5, 3, 0, 1);   // FENCE_I with drain and ack stalls
    run_txn(2'd2, 0, 0, 4, 1);   // SFENCE_VMA held off by halt
    run_txn(2'd3, 0, 0, 0, 0);   // reserved op, back-to-back re-accept

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int p, a;
      op = 2'($urandom_range(0, 3));
      p = (op == 2'd3) ? 0 : $urandom_range(0, 6);
      a = (op <= 2'd1) ? $urandom_range(0, 6) : 0;
      run_txn(op, p, a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    run_txn(2'd0, 0, 14, 0, 1);  // one short of the watchdog threshold
    run_txn(2'd0, 0, 15, 0, 1);  // reaches threshold on the last flush cycle
    run_txn(2'd1, 2, 20, 0, 1);  // flag stays sticky through later sequences

    // Reset while waiting in D$ flush.
    @(posedge clk); #1;
    n = cyc;
    req_valid = 1'b1; req_op = 2'd0; halt = 1'b0; no_st = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (cyc < n + 4) begin @(posedge clk); #1; end
    check("pre_reset_dflush", dcache_flush, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dflush", dcache_flush, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_timeout", timeout, 0);
    check("arst_stall", stall_cnt, 0);
    exp_to = 1'b0;
    exp_stall = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_txn(2'd1, 1, 1, 0, 1);
    run_txn(2'd2, 3, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("final_idle", busy, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
